// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises the fetch (stage12), operand-read (stage3) and
// save (stage5) request/ready handshakes onto the single-port ram macro.
// Fixed priority stage5 > stage3 > stage12, with a starvation guard that
// forces a fetch grant after STARVE_LIMIT consecutive lost arbitrations.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              ram_clk,
  input  logic              rst,

  input  logic              stage12_read,
  input  logic [ADDR_W-1:0] stage12_read_address,
  output logic              stage12_read_ready,
  output logic [DATA_W-1:0] stage12_read_data_out,

  input  logic              stage3_read,
  input  logic [ADDR_W-1:0] stage3_read_address,
  output logic              stage3_read_ready,
  output logic [DATA_W-1:0] stage3_read_data_out,

  input  logic              stage5_save,
  input  logic [ADDR_W-1:0] stage5_save_address,
  input  logic [DATA_W-1:0] stage5_save_data_in,
  output logic              stage5_save_ready,

  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,

  output logic [1:0]        grant
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  localparam logic [1:0] GRANT_NONE  = 2'd0;
  localparam logic [1:0] GRANT_FETCH = 2'd1;
  localparam logic [1:0] GRANT_OPND  = 2'd2;
  localparam logic [1:0] GRANT_SAVE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_starve_cnt;

  logic       w_any_req;
  logic       w_starved;
  logic [1:0] w_winner;
  logic       w_grant_now;
  logic       w_owner_req;

  // Arbitration: starvation guard first, then fixed priority
  always_comb begin
    w_any_req = stage12_read | stage3_read | stage5_save;
    w_starved = stage12_read && (r_starve_cnt == STARVE_MAX);
    w_winner  = GRANT_NONE;
    if (w_starved) begin
      w_winner = GRANT_FETCH;
    end else if (stage5_save) begin
      w_winner = GRANT_SAVE;
    end else if (stage3_read) begin
      w_winner = GRANT_OPND;
    end else if (stage12_read) begin
      w_winner = GRANT_FETCH;
    end
    w_grant_now = (r_state == S_IDLE) && w_any_req;
  end

  // Live request level of the current owner, watched in HOLD
  always_comb begin
    w_owner_req = 1'b0;
    case (grant)
      GRANT_FETCH: w_owner_req = stage12_read;
      GRANT_OPND:  w_owner_req = stage3_read;
      GRANT_SAVE:  w_owner_req = stage5_save;
      default:     w_owner_req = 1'b0;
    endcase
  end

  // Count grants lost by a waiting fetch; any fetch grant or idle fetch clears it
  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (!stage12_read) begin
      r_starve_cnt <= '0;
    end else if (w_grant_now) begin
      if (w_winner == GRANT_FETCH) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != CNT_SAT) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  // Access sequencer: grant/latch, RAM sample, capture + ready, hold until release
  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) begin
      r_state               <= S_IDLE;
      grant                 <= GRANT_NONE;
      ram_write_enable      <= 1'b0;
      ram_address           <= '0;
      ram_data_in           <= '0;
      stage12_read_ready    <= 1'b0;
      stage3_read_ready     <= 1'b0;
      stage5_save_ready     <= 1'b0;
      stage12_read_data_out <= '0;
      stage3_read_data_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ram_write_enable <= 1'b0;
          if (w_any_req) begin
            grant   <= w_winner;
            r_state <= S_ACCESS;
            case (w_winner)
              GRANT_SAVE: begin
                ram_address      <= stage5_save_address;
                ram_data_in      <= stage5_save_data_in;
                ram_write_enable <= 1'b1;
              end
              GRANT_OPND: begin
                ram_address <= stage3_read_address;
              end
              default: begin
                ram_address <= stage12_read_address;
              end
            endcase
          end
        end

        S_ACCESS: begin
          // RAM samples address/write on this edge; the write strobe ends here
          ram_write_enable <= 1'b0;
          r_state          <= S_CAPTURE;
        end

        S_CAPTURE: begin
          ram_write_enable <= 1'b0;
          r_state          <= S_HOLD;
          case (grant)
            GRANT_FETCH: begin
              stage12_read_data_out <= ram_data_out;
              stage12_read_ready    <= 1'b1;
            end
            GRANT_OPND: begin
              stage3_read_data_out <= ram_data_out;
              stage3_read_ready    <= 1'b1;
            end
            GRANT_SAVE: begin
              stage5_save_ready <= 1'b1;
            end
            default: begin
              r_state <= S_IDLE;
            end
          endcase
        end

        S_HOLD: begin
          if (!w_owner_req) begin
            stage12_read_ready <= 1'b0;
            stage3_read_ready  <= 1'b0;
            stage5_save_ready  <= 1'b0;
            grant              <= GRANT_NONE;
            r_state            <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Clocked three-port arbiter between the pipeline stages and the single-port `ram` macro. Ports: stage12 instruction fetch, stage3 operand read, stage5 result save. It serialises their level-based req/ready handshakes onto one RAM port under a fixed priority with a starvation guard for fetch. All decisions are made on `ram_clk` edges, with no event-triggered blocks.

## Interface
- `ADDR_W`, 16, address width for all ports and the RAM.
- `DATA_W`, 8, data width.
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which stage12 is forced to win (range 1..15).

Ports:
- `ram_clk` in 1: the only clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `stage12_read` in 1: fetch request, level.
- `stage12_read_address` in ADDR_W: fetch address.
- `stage12_read_ready` out 1: fetch complete; data valid.
- `stage12_read_data_out` out DATA_W: fetched byte.
- `stage3_read` in 1: operand read request, level.
- `stage3_read_address` in ADDR_W: operand read address.
- `stage3_read_ready` out 1: operand read complete.
- `stage3_read_data_out` out DATA_W: operand byte.
- `stage5_save` in 1: save request, level.
- `stage5_save_address` in ADDR_W: save address.
- `stage5_save_data_in` in DATA_W: byte to store.
- `stage5_save_ready` out 1: save committed.
- `ram_write_enable` out 1: to `ram`.
- `ram_address` out ADDR_W: to `ram`.
- `ram_data_in` out DATA_W: to `ram`.
- `ram_data_out` in DATA_W: from `ram`. Registered; valid one edge after the address is sampled.
- `grant` out 2: current owner. 0 = none, 1 = stage12, 2 = stage3, 3 = stage5.

## Operation
- **States:** IDLE, ACCESS, CAPTURE, HOLD.
- **IDLE:** if any request is high, pick a winner, latch its address (and data for save) into `ram_address`/`ram_data_in`, set `grant`, set `ram_write_enable` = 1 only for stage5, then go to ACCESS. With no request, stay in IDLE with `ram_write_enable` = 0.
- **ACCESS:** the RAM samples address/write on this edge. Go to CAPTURE.
- **CAPTURE:** set `ram_write_enable` <= 0.
  - For a read, register `ram_data_out` into the winner's `*_data_out`.
  - Assert the winner's ready.
  - Go to HOLD.
- **HOLD:** the winner's ready stays 1 while its request is high. On the first edge that samples its request low: clear ready, set `grant` = 0, go to IDLE.
- **Priority:** stage5 > stage3 > stage12. The starvation guard overrides this.
- **Starvation counter (4 bits):**
  - Increments on each grant to stage3/stage5 while `stage12_read` is high.
  - Clears on a stage12 grant, or on any edge with `stage12_read` low.
  - When the counter equals `STARVE_LIMIT`, stage12 wins the next arbitration regardless of other requests.
- **Sampling:** address and data are sampled only at grant. Later changes are ignored until the next grant.
- **Data hold:** non-winning `*_data_out` keep their last value. Data outputs hold after ready falls.
- **Early request drop:** if the requester drops its request during ACCESS/CAPTURE, the access still completes. Ready is then high for exactly one cycle, since HOLD sees the request low on the next edge.
- **Reset:** asynchronous low forces the following immediately:
  - IDLE, `grant` = 0, all ready = 0, all `*_data_out` = 0.
  - `ram_write_enable` = 0, `ram_address` = 0, `ram_data_in` = 0, counter = 0.
- **Reset mid-operation:** the access is aborted. A write whose ACCESS edge has already passed stays committed; otherwise it is not performed.

## Timing
- Request high before edge E0 (IDLE) leads to: grant at E0, RAM sample at E1, ready high after E2.
- Request-to-ready latency is 3 edges.
- After the requester drops its request, the HOLD-exit edge clears ready. The earliest next grant is one edge later, giving a minimum of 4 cycles per access with immediate drop.
- `ram_write_enable` is high for exactly one cycle per save (E0 to E1).
- Simultaneous requests in IDLE: one grant. The losers wait in IDLE and are re-evaluated after HOLD exits.
- A request that rises in the same cycle its own HOLD exits is treated as a new request at the next IDLE edge.

## Test plan
- **Single fetch:** RAM[0x0010] = 0xA5; raise `stage12_read` with address 0x0010. Require `stage12_read_ready` 3 edges later with data 0xA5, `grant` = 1 during the transaction, and ready low one edge after the request drops.
- **Save then read:** save 0x3C to 0x0200, then stage3 read of 0x0200. Require `ram_write_enable` high for exactly 1 cycle and read data 0x3C.
- **Simultaneous requests:** all three requests high in the same cycle. Require grant order 3, 2, 1, each completing with correct data and no overlap of ready signals.
- **Starvation guard:** `STARVE_LIMIT` = 2. Hold `stage12_read` high and re-raise stage5 continuously. Require stage12 to be granted after 2 stage5 grants, then the counter returns to 0.
- **Reset during a save:** assert `rst` low during ACCESS of a save to 0x0300 (old value 0x11). Require all outputs to go to 0 asynchronously and RAM[0x0300] = 0x11.
- **Early drop:** drop `stage3_read` one edge after grant. Require a one-cycle `stage3_read_ready` pulse with correct data, then IDLE.
